// File: rtl/seq_mag_comp_if.sv
// Operand/result handshake bundle for seq_mag_comp: operands in on a
// valid/ready pair, compare result out on a second valid/ready pair.
interface seq_mag_comp_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CW-1:0]    chunks_used;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, eq, gt, lt, chunks_used
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, eq, gt, lt, chunks_used
  );
endinterface

// File: rtl/seq_mag_comp.sv
// Sequential magnitude comparator: walks CHUNK-bit slices from the MSB down,
// stopping at the first differing slice; signed mode biases the top slice.
module seq_mag_comp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mag_comp_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_param
    $error("seq_mag_comp: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic             eq_q, gt_q, lt_q;
  logic             eq_d, gt_d, lt_d;
  logic [CW-1:0]    cu_q, cu_d;
  logic             load, shift, res_we;
  logic             is_top;
  logic [CHUNK-1:0] ka, kb;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [CHUNK-1:0] chunk_key(input logic [CHUNK-1:0] c,
                                                 input logic flip_msb);
    logic [CHUNK-1:0] k;
    k = c;
    if (flip_msb) k[CHUNK-1] = ~c[CHUNK-1];
    return k;
  endfunction

  assign is_top = (idx_q == IW'(NCHUNK - 1));
  assign ka     = chunk_key(a_q[WIDTH-1 -: CHUNK], sgn_q & is_top);
  assign kb     = chunk_key(b_q[WIDTH-1 -: CHUNK], sgn_q & is_top);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    shift   = 1'b0;
    res_we  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    cu_d    = CW'(NCHUNK) - CW'(idx_q);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          idx_d   = IW'(NCHUNK - 1);
          state_d = CMP;
        end
      end
      CMP: begin
        if (ka != kb) begin
          res_we  = 1'b1;
          eq_d    = 1'b0;
          gt_d    = (ka > kb);
          lt_d    = (ka < kb);
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_we  = 1'b1;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          shift   = 1'b1;
          idx_d   = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      cu_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (res_we) begin
        eq_q <= eq_d;
        gt_q <= gt_d;
        lt_q <= lt_d;
        cu_q <= cu_d;
      end
    end
  end

  // Operand shift registers: the chunk under test always sits at the MSB end.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      sgn_q <= bus.signed_mode;
    end else if (shift) begin
      a_q <= a_q << CHUNK;
      b_q <= b_q << CHUNK;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.eq          = eq_q;
  assign bus.gt          = gt_q;
  assign bus.lt          = lt_q;
  assign bus.chunks_used = cu_q;
endmodule

// File: tb/tb_seq_mag_comp.sv
// Scoreboard bench for seq_mag_comp: directed cases on a CHUNK=4 instance,
// then concurrent random traffic on CHUNK = 1, 4, 8 and 32 instances.
module tb_seq_mag_comp;
  typedef struct packed {
    logic       eq;
    logic       gt;
    logic       lt;
    logic [7:0] cu;
  } exp_t;

  localparam int NRND = 60;

  bit   clk = 1'b0;
  logic rst_n_d;
  logic rst_n_r;
  bit   go = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_rdone = 0;
  exp_t q_d[$];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input int ch);
    exp_t        e;
    int          n;
    logic [63:0] m;
    logic [63:0] d;
    n    = 32 / ch;
    m    = (64'h1 << ch) - 64'h1;
    e.cu = 8'(n);
    for (int i = n - 1; i >= 0; i--) begin
      d = (64'(a ^ b) >> (i * ch)) & m;
      if (d != 0) begin
        e.cu = 8'(n - i);
        break;
      end
    end
    e.eq = (a == b);
    e.gt = s ? ($signed(a) > $signed(b)) : (a > b);
    e.lt = !e.eq && !e.gt;
    return e;
  endfunction

  // ---------------- directed instance ----------------
  seq_mag_comp_if #(.WIDTH(32), .CHUNK(4)) if4 ();
  seq_mag_comp #(.WIDTH(32), .CHUNK(4)) dut4 (.clk(clk), .rst_n(rst_n_d), .bus(if4.slave));

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (!if4.in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!if4.in_ready) chk({tag, "_rdy_timeout"}, if4.in_ready, 1);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    if4.a           = a;
    if4.b           = b;
    if4.signed_mode = s;
    if4.in_valid    = 1'b1;
    q_d.push_back(model(a, b, s, 4));
  endtask

  // Called #1 after the accept edge; measures edges until out_valid and checks the result.
  task automatic wait_out(input string tag, output exp_t e);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!if4.out_valid && lat < 100);
    if (q_d.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      e = '0;
    end else begin
      e = q_d.pop_front();
      chk({tag, "_lat"}, lat, e.cu);
      chk({tag, "_ovld"}, if4.out_valid, 1);
      chk({tag, "_eq"}, if4.eq, e.eq);
      chk({tag, "_gt"}, if4.gt, e.gt);
      chk({tag, "_lt"}, if4.lt, e.lt);
      chk({tag, "_cu"}, if4.chunks_used, e.cu);
    end
  endtask

  task automatic run_d(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input string tag);
    exp_t e;
    wait_ready(tag);
    if4.out_ready = 1'b1;
    drive(a, b, s);
    @(posedge clk); #1;
    // Scramble inputs while the operation is in flight.
    if4.in_valid    = 1'b0;
    if4.a           = $urandom;
    if4.b           = $urandom;
    if4.signed_mode = ~s;
    wait_out(tag, e);
    @(posedge clk); #1;
    chk({tag, "_irdy_after"}, if4.in_ready, 1);
    chk({tag, "_ovld_after"}, if4.out_valid, 0);
  endtask

  task automatic backpressure();
    exp_t e;
    wait_ready("bp");
    if4.out_ready = 1'b0;
    drive(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          if4.in_valid = ~if4.in_valid;
          if4.a        = $urandom;
          if4.b        = $urandom;
          @(posedge clk); #1;
        end
      end
    join_none
    wait_out("bp", e);
    for (int i = 0; i < 5; i++) begin
      if4.in_valid = (i % 2 == 0);
      if4.a        = $urandom;
      @(posedge clk); #1;
      chk("bp_stall_ovld", if4.out_valid, 1);
      chk("bp_stall_irdy", if4.in_ready, 0);
      chk("bp_stall_eq", if4.eq, e.eq);
      chk("bp_stall_cu", if4.chunks_used, e.cu);
    end
    // Release with a new operand already offered: it must not be taken in the handoff cycle.
    if4.out_ready = 1'b1;
    drive(32'd5, 32'd3, 1'b0);
    @(posedge clk); #1;
    chk("bp_handoff_irdy", if4.in_ready, 1);
    chk("bp_handoff_ovld", if4.out_valid, 0);
    @(posedge clk); #1;
    chk("bp_accept_irdy", if4.in_ready, 0);
    if4.in_valid = 1'b0;
    wait_out("bp2", e);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    int seen;
    wait_ready("rst");
    if4.out_ready = 1'b1;
    drive(32'h12345678, 32'h12345678, 1'b1);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n_d = 1'b0;
    #1;
    chk("rst_mid_irdy", if4.in_ready, 1);
    chk("rst_mid_ovld", if4.out_valid, 0);
    chk("rst_mid_eq", if4.eq, 0);
    chk("rst_mid_gt", if4.gt, 0);
    chk("rst_mid_lt", if4.lt, 0);
    chk("rst_mid_cu", if4.chunks_used, 0);
    q_d.delete();
    @(posedge clk); #1;
    rst_n_d = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if4.out_valid) seen++;
    end
    chk("rst_no_result", seen, 0);
  endtask

  // ---------------- random instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
    seq_mag_comp_if #(.WIDTH(32), .CHUNK(CH)) rif ();
    seq_mag_comp #(.WIDTH(32), .CHUNK(CH)) u_dut (.clk(clk), .rst_n(rst_n_r), .bus(rif.slave));
    exp_t q[$];

    initial begin : drv
      logic [31:0] ra, rb;
      logic        rs;
      int          gd;
      rif.in_valid    = 1'b0;
      rif.a           = '0;
      rif.b           = '0;
      rif.signed_mode = 1'b0;
      wait (go);
      for (int t = 0; t < NRND; t++) begin
        @(posedge clk); #1;
        gd = 0;
        while (!rif.in_ready && gd < 300) begin
          @(posedge clk); #1;
          gd++;
        end
        if (!rif.in_ready) begin
          chk($sformatf("rnd_c%0d_rdy_timeout", CH), 0, 1);
          break;
        end
        ra = $urandom;
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
          2:       rb = ra ^ 32'h8000_0000;
          default: rb = $urandom;
        endcase
        rs = 1'($urandom_range(0, 1));
        rif.a           = ra;
        rif.b           = rb;
        rif.signed_mode = rs;
        rif.in_valid    = 1'b1;
        q.push_back(model(ra, rb, rs, CH));
        @(posedge clk); #1;
        rif.in_valid = 1'b0;
        rif.a        = $urandom;
        rif.b        = $urandom;
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    initial begin : mon
      exp_t e;
      int   got;
      int   cyc;
      rif.out_ready = 1'b0;
      got = 0;
      cyc = 0;
      wait (go);
      while (got < NRND && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        rif.out_ready = ($urandom_range(0, 2) != 0);
        if (rif.out_valid && rif.out_ready) begin
          got++;
          if (q.size() == 0) begin
            chk($sformatf("rnd_c%0d_spurious", CH), 1, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd_c%0d_res", CH), {rif.eq, rif.gt, rif.lt}, {e.eq, e.gt, e.lt});
            chk($sformatf("rnd_c%0d_onehot", CH),
                32'(rif.eq) + 32'(rif.gt) + 32'(rif.lt), 1);
            chk($sformatf("rnd_c%0d_cu", CH), rif.chunks_used, e.cu);
          end
        end
      end
      if (got < NRND) chk($sformatf("rnd_c%0d_timeout", CH), got, NRND);
      n_rdone++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int gd;
    exp_t e0;
    rst_n_d          = 1'b0;
    rst_n_r          = 1'b0;
    if4.in_valid     = 1'b0;
    if4.out_ready    = 1'b0;
    if4.a            = '0;
    if4.b            = '0;
    if4.signed_mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_irdy", if4.in_ready, 1);
    chk("reset_ovld", if4.out_valid, 0);
    chk("reset_eq", if4.eq, 0);
    chk("reset_gt", if4.gt, 0);
    chk("reset_lt", if4.lt, 0);
    chk("reset_cu", if4.chunks_used, 0);
    rst_n_d = 1'b1;
    rst_n_r = 1'b1;

    e0 = model(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 4);
    chk("model_sanity_gt", {e0.gt, e0.cu}, {1'b1, 8'd1});

    run_d(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "u_top_gt");
    run_d(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "s_top_lt");
    run_d(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "s_neg1_lt");
    run_d(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "u_max_gt");
    run_d(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "equal");
    run_d(32'h0000_0010, 32'h0000_0011, 1'b0, "late_lt");
    run_d(32'h7000_0000, 32'h6FFF_FFFF, 1'b1, "s_pos_gt");
    backpressure();
    reset_mid();

    go = 1'b1;
    gd = 0;
    while (n_rdone < 4 && gd < 60000) begin
      @(posedge clk);
      gd++;
    end
    if (n_rdone < 4) chk("rnd_done", n_rdone, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
